// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - run/stop interval timer around a WIDTH-bit up counter (optional COUNT_CTRL_IRQ_EN adds irq/irq_ack)
module count_ctrl #(
  parameter int WIDTH = 4,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [PW-1:0]    periods
`ifdef COUNT_CTRL_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_ack
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] PERIODS_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             terminal;
  logic             can_arm;
  logic [PW-1:0]    periods_inc;

  // Terminal count compares against the limit captured at start, not the live input
  assign terminal    = (counter == limit_q);
  assign can_arm     = (state == IDLE) || (state == DONE);
  assign periods_inc = (periods == PERIODS_MAX) ? periods : periods + PW'(1);

  // Status decode from registered state; tick is suppressed by a same-cycle pause or stop
  assign tick = (state == RUN) && terminal && !pause && !stop;
  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

  // Sequencer and datapath: stop beats start, start beats pause, pause beats counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      periods <= '0;
    end else if (stop) begin
      // periods is left alone so software can still read the tally after an abort
      state   <= IDLE;
      counter <= '0;
    end else if (start && can_arm) begin
      state   <= RUN;
      counter <= '0;
      limit_q <= limit;
      mode_q  <= mode;
      periods <= '0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
        end
        RUN: begin
          if (pause) begin
            state <= PAUSE;
          end else if (terminal) begin
            periods <= periods_inc;
            if (mode_q) begin
              counter <= '0;
            end else begin
              state <= DONE;
            end
          end else begin
            counter <= counter + WIDTH'(1);
          end
        end
        PAUSE: begin
          if (!pause) begin
            state <= RUN;
          end
        end
        DONE: begin
          counter <= limit_q;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COUNT_CTRL_IRQ_EN
  // Sticky interrupt: a new terminal count takes precedence over an acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (tick) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
